srio_type9_chan_demux: RTL and testbench

//  Strips SRIO Ftype 9 (streaming) segment headers from a 64-bit AXIS stream and forwards payload per channel.

---
 rtl/srio_type9_chan_demux.sv | 224 ++++++++++++++++++++++
 tb/tb_srio_type9_chan_demux.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srio_type9_chan_demux.sv
// ---------------------------------------------------------------------------
// srio_type9_chan_demux
//
// Strips SRIO Ftype 9 (data streaming) segment headers from a 64-bit AXIS
// stream and forwards the payload tagged with a per-channel TDEST. PDU
// segmentation (start/end) is tracked independently for every channel, so
// channels may interleave at segment granularity. Segments that are out of
// range, or that continue a PDU that was never started, are dropped and
// counted. A start arriving while the channel is already mid-PDU is counted
// as a sequence error and restarts the PDU.
//
// Header beat layout: tdata[63] = S (PDU start), tdata[62] = E (PDU end),
// tdata[15:0] = streamID.
//
// Ports
//   AXIS_ACLK      clock
//   AXIS_ARESET    synchronous active-high reset
//   S_AXIS_*       input segments (first beat of each segment is the header)
//   M_AXIS_*       payload (plus first-segment header when KEEP_HDR=1),
//                  TDEST = streamID - STREAMID_BASE
//   DROP_CNT       saturating count of dropped segments
//   SEQ_ERR_CNT    saturating count of S=1 received on an already open PDU
// ---------------------------------------------------------------------------
module srio_type9_chan_demux #(
  parameter int          NUM_CHAN      = 4,
  parameter int          CHAN_W        = 2,
  parameter logic [15:0] STREAMID_BASE = 16'h0000,
  parameter bit          KEEP_HDR      = 1'b1,
  parameter bit          TLAST_ON_SEG  = 1'b0,
  parameter int          TUSER_W       = 32
) (
  input  logic               AXIS_ACLK,
  input  logic               AXIS_ARESET,
  input  logic [63:0]        S_AXIS_TDATA,
  input  logic [TUSER_W-1:0] S_AXIS_TUSER,
  input  logic               S_AXIS_TLAST,
  input  logic               S_AXIS_TVALID,
  output logic               S_AXIS_TREADY,
  output logic [63:0]        M_AXIS_TDATA,
  output logic [TUSER_W-1:0] M_AXIS_TUSER,
  output logic [CHAN_W-1:0]  M_AXIS_TDEST,
  output logic               M_AXIS_TLAST,
  output logic               M_AXIS_TVALID,
  input  logic               M_AXIS_TREADY,
  output logic [15:0]        DROP_CNT,
  output logic [15:0]        SEQ_ERR_CNT
);

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_SEND = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 hold_valid_q, hold_valid_d;
  logic [63:0]          hold_data_q, hold_data_d;
  logic [TUSER_W-1:0]   hold_user_q, hold_user_d;
  logic                 hold_last_q, hold_last_d;
  logic [NUM_CHAN-1:0]  in_pdu_q, in_pdu_d;
  logic [CHAN_W-1:0]    tdest_q, tdest_d;
  logic                 eseg_q, eseg_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;
  logic [15:0]          seq_err_cnt_q, seq_err_cnt_d;

  logic                 hdr_s, hdr_e;
  logic [15:0]          hdr_sid;
  logic [16:0]          sid_off;
  logic                 hdr_in_range;
  logic                 hdr_open;
  logic                 hdr_valid;
  logic [CHAN_W-1:0]    hdr_ch;

  logic                 fwd;
  logic                 out_last;
  logic [CHAN_W-1:0]    out_dest;
  logic                 consume;
  logic                 load;
  logic                 s_ready;

  // Header decode of whatever sits in the holding register. Only meaningful
  // while the FSM is in ST_HDR. The offset is computed one bit wider so a
  // streamID below the base cannot wrap into the valid channel range.
  always_comb begin
    hdr_s        = hold_data_q[63];
    hdr_e        = hold_data_q[62];
    hdr_sid      = hold_data_q[15:0];
    sid_off      = {1'b0, hdr_sid} - {1'b0, STREAMID_BASE};
    hdr_in_range = (hdr_sid >= STREAMID_BASE) && (sid_off < 17'(NUM_CHAN));
    hdr_ch       = sid_off[CHAN_W-1:0];
    hdr_open     = 1'b0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (sid_off == 17'(i)) begin
        hdr_open = in_pdu_q[i];
      end
    end
    // A continuation segment is only legal on a channel with an open PDU.
    hdr_valid = hdr_in_range && (hdr_s || hdr_open);
  end

  // Output path: decide whether the held beat is forwarded or silently
  // discarded. Discarded beats are consumed without waiting for M_TREADY so
  // dropped segments never stall the input.
  always_comb begin
    fwd      = 1'b0;
    out_last = 1'b0;
    out_dest = tdest_q;
    unique case (state_q)
      ST_HDR: begin
        if (hold_valid_q) begin
          out_dest = hdr_ch;
        end
        if (hdr_valid) begin
          fwd      = hdr_s & KEEP_HDR;
          out_last = hold_last_q & (hdr_e | TLAST_ON_SEG);
        end
      end
      ST_SEND: begin
        fwd      = 1'b1;
        out_last = hold_last_q & (eseg_q | TLAST_ON_SEG);
      end
      ST_DROP: begin
        fwd = 1'b0;
      end
      default: begin
        fwd = 1'b0;
      end
    endcase
    consume = hold_valid_q & (~fwd | M_AXIS_TREADY);
    s_ready = ~hold_valid_q | consume;
    load    = S_AXIS_TVALID & s_ready;
  end

  // Next-state logic. All segment bookkeeping happens on the cycle the held
  // beat is consumed, so a forwarded header waiting on backpressure does not
  // update channel state or counters twice.
  always_comb begin
    state_d       = state_q;
    in_pdu_d      = in_pdu_q;
    tdest_d       = tdest_q;
    eseg_d        = eseg_q;
    drop_cnt_d    = drop_cnt_q;
    seq_err_cnt_d = seq_err_cnt_q;

    hold_valid_d = load | (hold_valid_q & ~consume);
    hold_data_d  = hold_data_q;
    hold_user_d  = hold_user_q;
    hold_last_d  = hold_last_q;
    if (load) begin
      hold_data_d = S_AXIS_TDATA;
      hold_user_d = S_AXIS_TUSER;
      hold_last_d = S_AXIS_TLAST;
    end

    if (consume) begin
      unique case (state_q)
        ST_HDR: begin
          if (hdr_valid) begin
            for (int i = 0; i < NUM_CHAN; i++) begin
              if (sid_off == 17'(i)) begin
                in_pdu_d[i] = ~hdr_e;
              end
            end
            tdest_d = hdr_ch;
            eseg_d  = hdr_e;
            if (hdr_s && hdr_open && (seq_err_cnt_q != 16'hFFFF)) begin
              seq_err_cnt_d = seq_err_cnt_q + 16'd1;
            end
            state_d = hold_last_q ? ST_HDR : ST_SEND;
          end else begin
            if (drop_cnt_q != 16'hFFFF) begin
              drop_cnt_d = drop_cnt_q + 16'd1;
            end
            state_d = hold_last_q ? ST_HDR : ST_DROP;
          end
        end
        ST_SEND, ST_DROP: begin
          if (hold_last_q) begin
            state_d = ST_HDR;
          end
        end
        default: begin
          state_d = ST_HDR;
        end
      endcase
    end
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      state_q       <= ST_HDR;
      hold_valid_q  <= 1'b0;
      hold_data_q   <= '0;
      hold_user_q   <= '0;
      hold_last_q   <= 1'b0;
      in_pdu_q      <= '0;
      tdest_q       <= '0;
      eseg_q        <= 1'b0;
      drop_cnt_q    <= '0;
      seq_err_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      hold_valid_q  <= hold_valid_d;
      hold_data_q   <= hold_data_d;
      hold_user_q   <= hold_user_d;
      hold_last_q   <= hold_last_d;
      in_pdu_q      <= in_pdu_d;
      tdest_q       <= tdest_d;
      eseg_q        <= eseg_d;
      drop_cnt_q    <= drop_cnt_d;
      seq_err_cnt_q <= seq_err_cnt_d;
    end
  end

  assign S_AXIS_TREADY = s_ready;
  assign M_AXIS_TDATA  = hold_data_q;
  assign M_AXIS_TUSER  = hold_user_q;
  assign M_AXIS_TDEST  = out_dest;
  assign M_AXIS_TVALID = hold_valid_q & fwd;
  assign M_AXIS_TLAST  = hold_valid_q & fwd & out_last;
  assign DROP_CNT      = drop_cnt_q;
  assign SEQ_ERR_CNT   = seq_err_cnt_q;

endmodule

// File: tb/tb_srio_type9_chan_demux.sv
// ---------------------------------------------------------------------------
// tb_srio_type9_chan_demux
//
// Drives SRIO type 9 segments described by a table of records. Each record
// carries the segment inputs and the hand-derived expected outcome
// (forwarded or not, TDEST, PDU-end TLAST, counter values afterwards).
// Expected output beats are queued when a beat is driven and popped by a
// monitor on every output handshake.
// ---------------------------------------------------------------------------
module tb_srio_type9_chan_demux;

  localparam int TUSER_W = 32;
  localparam int CHAN_W  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [63:0]        s_tdata;
  logic [TUSER_W-1:0] s_tuser;
  logic               s_tlast;
  logic               s_tvalid;
  logic               s_tready;
  logic [63:0]        m_tdata;
  logic [TUSER_W-1:0] m_tuser;
  logic [CHAN_W-1:0]  m_tdest;
  logic               m_tlast;
  logic               m_tvalid;
  logic               m_tready;
  logic [15:0]        drop_cnt;
  logic [15:0]        seq_err_cnt;

  always #5 clk = ~clk;

  srio_type9_chan_demux #(
    .NUM_CHAN      (4),
    .CHAN_W        (CHAN_W),
    .STREAMID_BASE (16'h0000),
    .KEEP_HDR      (1'b1),
    .TLAST_ON_SEG  (1'b0),
    .TUSER_W       (TUSER_W)
  ) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESET   (rst),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TUSER  (s_tuser),
    .S_AXIS_TLAST  (s_tlast),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TREADY (s_tready),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TUSER  (m_tuser),
    .M_AXIS_TDEST  (m_tdest),
    .M_AXIS_TLAST  (m_tlast),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TREADY (m_tready),
    .DROP_CNT      (drop_cnt),
    .SEQ_ERR_CNT   (seq_err_cnt)
  );

  typedef struct {
    logic [63:0]        data;
    logic [TUSER_W-1:0] user;
    logic [CHAN_W-1:0]  dest;
    logic               last;
  } beat_t;

  typedef struct {
    logic [15:0]       sid;
    bit                s;
    bit                e;
    int                npay;
    bit                hdr_fwd;
    bit                pay_fwd;
    logic [CHAN_W-1:0] dest;
    bit                last;
    int                drop;
    int                seq;
  } seg_rec_t;

  beat_t    exp_q[$];
  beat_t    mon_exp;
  seg_rec_t tbl[16];
  int       n_cmp = 0;
  int       n_fail = 0;
  bit       rand_ready = 1'b0;

  function automatic seg_rec_t mk(input logic [15:0] sid, input bit s, input bit e,
                                  input int npay, input bit hdr_fwd, input bit pay_fwd,
                                  input logic [CHAN_W-1:0] dest, input bit last,
                                  input int drop, input int seq);
    seg_rec_t r;
    r.sid = sid; r.s = s; r.e = e; r.npay = npay;
    r.hdr_fwd = hdr_fwd; r.pay_fwd = pay_fwd; r.dest = dest; r.last = last;
    r.drop = drop; r.seq = seq;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic set_ready();
    m_tready = rand_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    set_ready();
  endtask

  // Present one beat and hold it until the DUT accepts it; returns the
  // number of cycles the beat had to wait.
  task automatic applyBeat(input logic [63:0] d, input logic [TUSER_W-1:0] u,
                           input logic l, output int stalls);
    bit done;
    bit acc;
    done = 1'b0;
    stalls = 0;
    s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      acc = s_tready;
      step();
      if (acc) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (stalls > 500) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL input_accept_timeout: got no S_TREADY, expected acceptance");
          done = 1'b1;
        end
      end
    end
  endtask

  // Drive one segment (header + payload), queueing expected output beats.
  // abort_after >= 0 stops after that many payload beats.
  task automatic applyStimulus(input seg_rec_t r, input int abort_after, output int stalls_total);
    logic [63:0]        hdr;
    logic [63:0]        d;
    logic [TUSER_W-1:0] u;
    beat_t              b;
    int                 st;
    stalls_total = 0;
    hdr = {$urandom, $urandom};
    hdr[63] = r.s;
    hdr[62] = r.e;
    hdr[15:0] = r.sid;
    u = $urandom;
    if (r.hdr_fwd) begin
      b.data = hdr; b.user = u; b.dest = r.dest;
      b.last = (r.npay == 0) ? r.last : 1'b0;
      exp_q.push_back(b);
    end
    applyBeat(hdr, u, r.npay == 0, st);
    stalls_total += st;
    for (int k = 0; k < r.npay; k++) begin
      if (abort_after < 0 || k < abort_after) begin
        d = {$urandom, $urandom};
        u = $urandom;
        if (r.pay_fwd) begin
          b.data = d; b.user = u; b.dest = r.dest;
          b.last = (k == r.npay - 1) ? r.last : 1'b0;
          exp_q.push_back(b);
        end
        applyBeat(d, u, k == r.npay - 1, st);
        stalls_total += st;
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain(input int exp_drop, input int exp_seq, input string tag);
    int n;
    n = 0;
    step();
    step();
    while ((exp_q.size() != 0 || m_tvalid) && n < 300) begin
      step();
      n++;
    end
    checkOutput({tag, "_pending_beats"}, 64'(exp_q.size()), 64'd0);
    checkOutput({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
    checkOutput({tag, "_seq_err_cnt"}, 64'(seq_err_cnt), 64'(exp_seq));
  endtask

  // Scoreboard monitor: every output handshake must match the queue head.
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_beat: got data=%h dest=%0d last=%0d, expected no beat",
                 m_tdata, m_tdest, m_tlast);
      end else begin
        mon_exp = exp_q.pop_front();
        if (m_tdata !== mon_exp.data || m_tuser !== mon_exp.user ||
            m_tdest !== mon_exp.dest || m_tlast !== mon_exp.last) begin
          n_fail++;
          $display("[TB] FAIL out_beat: got data=%h user=%h dest=%0d last=%0d, expected data=%h user=%h dest=%0d last=%0d",
                   m_tdata, m_tuser, m_tdest, m_tlast,
                   mon_exp.data, mon_exp.user, mon_exp.dest, mon_exp.last);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int st;
    seg_rec_t r;

    //          sid       S  E  npay hdrF payF dest last drop seq
    tbl[0]  = mk(16'd2,    1, 1, 4,   1,   1,   2,   1,   0,   0);
    tbl[1]  = mk(16'd0,    1, 0, 3,   1,   1,   0,   0,   0,   0);
    tbl[2]  = mk(16'd0,    0, 0, 3,   0,   1,   0,   0,   0,   0);
    tbl[3]  = mk(16'd0,    0, 1, 3,   0,   1,   0,   1,   0,   0);
    tbl[4]  = mk(16'd1,    1, 0, 2,   1,   1,   1,   0,   0,   0);
    tbl[5]  = mk(16'd3,    1, 1, 2,   1,   1,   3,   1,   0,   0);
    tbl[6]  = mk(16'd1,    0, 1, 2,   0,   1,   1,   1,   0,   0);
    tbl[7]  = mk(16'd4,    1, 1, 5,   0,   0,   0,   0,   1,   0);
    tbl[8]  = mk(16'd0,    0, 0, 2,   0,   0,   0,   0,   2,   0);
    tbl[9]  = mk(16'd0,    1, 0, 2,   1,   1,   0,   0,   2,   0);
    tbl[10] = mk(16'd0,    1, 1, 2,   1,   1,   0,   1,   2,   1);
    tbl[11] = mk(16'd2,    1, 1, 0,   1,   0,   2,   1,   2,   1);
    tbl[12] = mk(16'd1,    0, 0, 0,   0,   0,   0,   0,   3,   1);
    tbl[13] = mk(16'd2,    1, 0, 0,   1,   0,   2,   0,   3,   1);
    tbl[14] = mk(16'd2,    0, 1, 2,   0,   1,   2,   1,   3,   1);
    tbl[15] = mk(16'hFFFF, 1, 1, 1,   0,   0,   0,   0,   4,   1);

    rst = 1'b1;
    s_tdata = '0; s_tuser = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
    m_tready = 1'b1;
    step();
    step();
    checkOutput("reset_m_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("reset_m_tdata", m_tdata, 64'd0);
    checkOutput("reset_s_tready", 64'(s_tready), 64'd1);
    checkOutput("reset_drop_cnt", 64'(drop_cnt), 64'd0);
    checkOutput("reset_seq_err_cnt", 64'(seq_err_cnt), 64'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 16; i++) begin
      applyStimulus(tbl[i], -1, st);
      if (!tbl[i].hdr_fwd && !tbl[i].pay_fwd) begin
        checkOutput($sformatf("seg%0d_drop_stalls", i), 64'(st), 64'd0);
      end
      drain(tbl[i].drop, tbl[i].seq, $sformatf("seg%0d", i));
    end

    // Backpressure phase: ready low about 30% of cycles.
    rand_ready = 1'b1;
    applyStimulus(mk(16'd3, 1, 0, 4, 1, 1, 3, 0, 4, 1), -1, st);
    applyStimulus(mk(16'd3, 0, 1, 3, 0, 1, 3, 1, 4, 1), -1, st);
    drain(4, 1, "bp_pdu");

    // Reset in the middle of a forwarded segment on ch1.
    applyStimulus(mk(16'd1, 1, 0, 6, 1, 1, 1, 0, 4, 1), 3, st);
    rst = 1'b1;
    s_tvalid = 1'b0;
    step();
    checkOutput("midreset_m_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("midreset_m_tdata", m_tdata, 64'd0);
    checkOutput("midreset_m_tuser", 64'(m_tuser), 64'd0);
    checkOutput("midreset_m_tdest", 64'(m_tdest), 64'd0);
    checkOutput("midreset_m_tlast", 64'(m_tlast), 64'd0);
    checkOutput("midreset_drop_cnt", 64'(drop_cnt), 64'd0);
    checkOutput("midreset_seq_err_cnt", 64'(seq_err_cnt), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    step();

    // ch1 PDU state was cleared, so a continuation is now an orphan.
    r = mk(16'd1, 0, 1, 2, 0, 0, 0, 0, 1, 0);
    applyStimulus(r, -1, st);
    checkOutput("post_reset_orphan_stalls", 64'(st), 64'd0);
    drain(1, 0, "post_reset_orphan");
    applyStimulus(mk(16'd1, 1, 1, 5, 1, 1, 1, 1, 1, 0), -1, st);
    drain(1, 0, "post_reset_pdu");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
